// File: rtl/rs_latch_driver.sv
// rs_latch_driver
//   Clocked, command-driven driver for an external gated RS NOR latch
//   (active-high S, R, C). A command accepted over a valid/ready handshake
//   runs through these phases:
//     1. setup:   S/R driven with C low
//     2. pulse:   C high, so the latch is transparent
//     3. hold:    S/R held with C low
//     4. sync:    two idle cycles so Q/Qbar settle through the synchronizers
//   Finally the synchronized Q is sampled and the result reported on done/err.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command request
//   cmd_ready  out  driver idle; accept on cmd_valid && cmd_ready
//   cmd_op     in   2'b00 SET, 2'b01 RESET, 2'b10 HOLD, 2'b11 FORBIDDEN (rejected)
//   S, R, C    out  latch set / reset / enable
//   Q, Qbar    in   latch outputs, asynchronous to clk
//   done       out  one-cycle completion strobe
//   err        out  valid with done: check failed or command rejected
//   q_sample   out  synchronized Q captured at done, held until the next done
module rs_latch_driver #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    output logic       S,
    output logic       R,
    output logic       C,
    input  logic       Q,
    input  logic       Qbar,
    output logic       done,
    output logic       err,
    output logic       q_sample
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_SYNC,
        ST_DONE
    } state_t;

    localparam logic [1:0] OP_SET   = 2'b00;
    localparam logic [1:0] OP_RESET = 2'b01;
    localparam logic [1:0] OP_BAD   = 2'b11;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               exp_q, exp_d;
    logic               s_q, s_d;
    logic               r_q, r_d;
    logic               c_q, c_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               q_sample_q, q_sample_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               q_meta_q, q_sync_q;
    logic               qb_meta_q, qb_sync_q;
    logic               drive;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        exp_d       = exp_q;
        q_sample_d  = q_sample_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_op == OP_BAD) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        op_d    = cmd_op;
                        // HOLD must leave the latch unchanged, so the last sampled value is expected
                        exp_d   = (cmd_op == OP_SET)   ? 1'b1 :
                                  (cmd_op == OP_RESET) ? 1'b0 : q_sample_q;
                        state_d = ST_SETUP;
                        cnt_d   = CNT_W'(SETUP_CYC - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_SYNC;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SYNC: begin
                if (cnt_q == '0) begin
                    // Result is registered on entry to DONE so it appears together with the strobe
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    q_sample_d = q_sync_q;
                    err_d      = (q_sync_q != exp_q) || (q_sync_q == qb_sync_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered pins line up with the state
        drive       = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
        s_d         = drive && (op_d == OP_SET);
        r_d         = drive && (op_d == OP_RESET);
        c_d         = (state_d == ST_PULSE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            exp_q       <= 1'b0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            c_q         <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            q_sample_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            q_meta_q    <= 1'b0;
            q_sync_q    <= 1'b0;
            qb_meta_q   <= 1'b0;
            qb_sync_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            exp_q       <= exp_d;
            s_q         <= s_d;
            r_q         <= r_d;
            c_q         <= c_d;
            done_q      <= done_d;
            err_q       <= err_d;
            q_sample_q  <= q_sample_d;
            cmd_ready_q <= cmd_ready_d;
            q_meta_q    <= Q;
            q_sync_q    <= q_meta_q;
            qb_meta_q   <= Qbar;
            qb_sync_q   <= qb_meta_q;
        end
    end

    assign S         = s_q;
    assign R         = r_q;
    assign C         = c_q;
    assign done      = done_q;
    assign err       = err_q;
    assign q_sample  = q_sample_q;
    assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_rs_latch_driver.sv
// tb_rs_latch_driver
//   Directed bench for rs_latch_driver with a behavioural gated RS NOR latch
//   model. The model can be forced to Q stuck at 0, or to Q = Qbar = 1.
module tb_rs_latch_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic       S, R, C;
    logic       Q, Qbar;
    logic       done, err, q_sample;

    logic       lq = 1'b0;
    logic       stuck0 = 1'b0;
    logic       force_both = 1'b0;

    int         n_cmp = 0;
    int         n_bad = 0;

    rs_latch_driver #(
        .SETUP_CYC(2),
        .PULSE_CYC(4),
        .HOLD_CYC (2),
        .CNT_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .S        (S),
        .R        (R),
        .C        (C),
        .Q        (Q),
        .Qbar     (Qbar),
        .done     (done),
        .err      (err),
        .q_sample (q_sample)
    );

    always #5 clk = ~clk;

    // Gated RS latch: transparent while C is high
    always @(S or R or C) begin
        if (C) begin
            if (S && !R)      lq = 1'b1;
            else if (R && !S) lq = 1'b0;
        end
    end

    assign Q    = force_both ? 1'b1 : (stuck0 ? 1'b0 : lq);
    assign Qbar = force_both ? 1'b1 : (stuck0 ? 1'b1 : ~lq);

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE and check every cycle up to the return to IDLE.
    // Cycle k is observed 1 time unit after the k-th edge following the accept edge.
    task automatic run_cmd(input logic [1:0] op, input bit hold_valid,
                           input logic e_err, input logic e_qs);
        int  n;
        bit  busy;
        n = (op == 2'b11) ? 1 : 11;
        check("ready_before_accept", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        for (int k = 1; k <= n; k++) begin
            step();
            if (k == 1 && !hold_valid) cmd_valid = 1'b0;
            busy = (op != 2'b11) && (k <= 8);
            check($sformatf("S_op%0d_k%0d", op, k), S, busy && (op == 2'b00));
            check($sformatf("R_op%0d_k%0d", op, k), R, busy && (op == 2'b01));
            check($sformatf("C_op%0d_k%0d", op, k), C, (op != 2'b11) && (k >= 3) && (k <= 6));
            check($sformatf("done_op%0d_k%0d", op, k), done, k == n);
            check($sformatf("ready_op%0d_k%0d", op, k), cmd_ready, 1'b0);
            if (k == n) begin
                check($sformatf("err_op%0d", op), err, e_err);
                check($sformatf("qs_op%0d", op), q_sample, e_qs);
            end
        end
        step();
        check($sformatf("ready_after_op%0d", op), cmd_ready, 1'b1);
        check($sformatf("done_clear_op%0d", op), done, 1'b0);
    endtask

    initial begin
        // Power-on reset
        #2 rst_n = 1'b0;
        #3;
        check("rst_S", S, 1'b0);
        check("rst_R", R, 1'b0);
        check("rst_C", C, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_qs", q_sample, 1'b0);
        check("rst_ready", cmd_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("ready_first_edge", cmd_ready, 1'b1);

        // Reset while C is high: outputs drop at once, no done follows
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        check("midpulse_C", C, 1'b1);
        check("midpulse_S", S, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_S", S, 1'b0);
        check("async_R", R, 1'b0);
        check("async_C", C, 1'b0);
        check("async_ready", cmd_ready, 1'b0);
        repeat (2) begin
            step();
            check("rst_no_done", done, 1'b0);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        check("ready_after_rerst", cmd_ready, 1'b1);
        check("qs_after_rerst", q_sample, 1'b0);

        // SET, then a rejected op leaves q_sample alone, then RESET
        run_cmd(2'b00, 1'b0, 1'b0, 1'b1);
        run_cmd(2'b11, 1'b0, 1'b1, 1'b1);
        run_cmd(2'b01, 1'b0, 1'b0, 1'b0);

        // Latch faults
        stuck0 = 1'b1;
        run_cmd(2'b00, 1'b0, 1'b1, 1'b0);
        stuck0     = 1'b0;
        force_both = 1'b1;
        run_cmd(2'b00, 1'b0, 1'b1, 1'b1);
        force_both = 1'b0;
        run_cmd(2'b01, 1'b0, 1'b0, 1'b0);

        // Back-to-back with cmd_valid held: SET then HOLD, second accept at T+12
        run_cmd(2'b00, 1'b1, 1'b0, 1'b1);
        run_cmd(2'b10, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
